lsu_store_buffer: RTL and testbench

- Sits between the load/store controller and the single-port data memory.
- Accepts byte-enabled word stores into a DEPTH-entry FIFO and retires them to memory in idle cycles.
- Gives loads priority on the memory port, with a registered 1-cycle read response.
- Stalls any load whose word address matches a pending store, so RAW ordering is preserved.

---
 rtl/lsu_store_buffer.sv | 159 +++++++++++++++
 tb/tb_lsu_store_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_store_buffer.sv
// Byte-enabled word store FIFO in front of a single-port data memory; loads win the port, stores drain in idle cycles.
// Load data returns 1 cycle after acceptance; loads stall on a word-address match with any pending store.
// st_ready drops when full; optional STORE_FWD_EN forwards a full-word youngest match instead of stalling.
module lsu_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [3:0]       st_be,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  output logic             ld_rvalid,
  output logic [31:0]      ld_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_we,
  input  logic [31:0]      mem_rdata,
  output logic             sb_empty,
  output logic [PTR_W:0]   sb_count
);

  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {SB_EMPTY, SB_PARTIAL, SB_FULL} sb_state_e;

  logic [29:0]      addr_q [DEPTH];
  logic [29:0]      addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [3:0]       be_q   [DEPTH];
  logic [3:0]       be_d   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  sb_state_e        state_q, state_d;
  logic             ld_rvalid_q, ld_rvalid_d;
  logic [31:0]      ld_rdata_q, ld_rdata_d;

  logic             hazard, ld_acc, mem_rd, drain, push;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [3:0]       young_be;
    hazard   = 1'b0;
    young_be = 4'h0;
    fwd_data = 32'h0;
    idx      = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == ld_addr[31:2])) begin
        hazard   = 1'b1;
        young_be = be_q[idx];
        fwd_data = data_q[idx];
      end
    end
`ifdef STORE_FWD_EN
    fwd_hit = hazard && (young_be == 4'hF);
`else
    fwd_hit = 1'b0;
`endif
  end

  assign ld_ready = !hazard || fwd_hit;
  assign ld_acc   = ld_valid && ld_ready;
  assign mem_rd   = ld_acc && !hazard;
  assign drain    = !reset && (count_q != '0) && !mem_rd;
  assign st_ready = (state_q != SB_FULL);
  assign push     = st_valid && st_ready;

  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_we    = 4'h0;
    if (mem_rd) begin
      mem_addr = {ld_addr[31:2], 2'b00};
    end else if (drain) begin
      mem_addr  = {addr_q[head_q], 2'b00};
      mem_wdata = data_q[head_q];
      mem_we    = be_q[head_q];
    end
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(drain);
    if (push) begin
      addr_d[tail_q] = st_addr[31:2];
      data_d[tail_q] = st_data;
      be_d[tail_q]   = st_be;
      tail_d         = tail_q + 1'b1;
    end
    if (drain) begin
      head_d = head_q + 1'b1;
    end
  end

  always_comb begin
    state_d = SB_PARTIAL;
    if (count_d == '0) begin
      state_d = SB_EMPTY;
    end else if (count_d == CNT_W'(DEPTH)) begin
      state_d = SB_FULL;
    end
  end

  always_comb begin
    ld_rvalid_d = ld_acc;
    ld_rdata_d  = ld_rdata_q;
    if (ld_acc) begin
      ld_rdata_d = fwd_hit ? fwd_data : mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= SB_EMPTY;
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= 32'h0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Payload needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  assign ld_rvalid = ld_rvalid_q;
  assign ld_rdata  = ld_rdata_q;
  assign sb_empty  = (state_q == SB_EMPTY);
  assign sb_count  = count_q;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Scoreboarded bench for lsu_store_buffer: expected memory writes and load data queued at handshake, compared on output.
module tb_lsu_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_be;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic        sb_empty;
  logic [2:0]  sb_count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] lq[$];
  logic [31:0] pmem [256];
  logic [31:0] amem [256];
  bit          pmem_init = 1'b0;
  bit          amem_init = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  lsu_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'hC0) return 32'h1234_5678;
    return 32'hA500_0000 ^ (i * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Physical memory: combinational read, byte-enabled write at posedge.
  assign mem_rdata = pmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!pmem_init) begin
      for (int i = 0; i < 256; i++) pmem[i] = init_word(i);
      pmem_init = 1'b1;
    end else if (mem_we != 4'h0) begin
      pmem[mem_addr[9:2]] = merge(pmem[mem_addr[9:2]], mem_wdata, mem_we);
    end
  end

  // Monitor: amem is the program-order memory image; loads see stores accepted strictly earlier.
  always @(negedge clk) begin
    wr_t e;
    if (!amem_init) begin
      for (int i = 0; i < 256; i++) amem[i] = init_word(i);
      amem_init = 1'b1;
    end
    if (mem_we != 4'h0) begin
      if (wq.size() == 0) check("unexpected_write", {28'h0, mem_we}, 32'h0);
      else begin
        e = wq.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wdata, e.data);
        check("wr_be", {28'h0, mem_we}, {28'h0, e.be});
      end
    end
    if (ld_rvalid) begin
      if (lq.size() == 0) check("unexpected_rvalid", {31'h0, ld_rvalid}, 32'h0);
      else check("ld_data", ld_rdata, lq.pop_front());
    end
    if (reset) begin
      wq.delete();
      lq.delete();
    end else begin
      if (ld_valid && ld_ready) lq.push_back(amem[ld_addr[9:2]]);
      if (st_valid && st_ready) begin
        wq.push_back('{addr: {st_addr[31:2], 2'b00}, data: st_data, be: st_be});
        amem[st_addr[9:2]] = merge(amem[st_addr[9:2]], st_data, st_be);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string tag);
    int k = 0;
    while (!sb_empty && k < 50) begin
      cyc();
      k++;
    end
    check(tag, {31'h0, sb_empty}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int          k;
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0;
    cyc(); cyc();
    @(negedge clk);
    check("rst_count", {29'h0, sb_count}, 32'h0);
    check("rst_empty", {31'h0, sb_empty}, 32'h1);
    check("rst_rvalid", {31'h0, ld_rvalid}, 32'h0);
    check("rst_rdata", ld_rdata, 32'h0);
    check("rst_st_ready", {31'h0, st_ready}, 32'h1);
    cyc();
    reset = 1'b0;

    // Single store drains the following cycle
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEAD_BEEF; st_be = 4'hF;
    cyc();
    st_valid = 1'b0;
    @(negedge clk);
    check("t1_we", {28'h0, mem_we}, 32'hF);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    check("t1_empty", {31'h0, sb_empty}, 32'h1);

    // Loads starve the drain until the buffer fills
    ld_valid = 1'b1; ld_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1; st_addr = 32'h10 + 32'(i * 4); st_data = 32'h0A0B_0C00 + 32'(i); st_be = 4'hF;
      cyc();
    end
    st_valid = 1'b0;
    @(negedge clk);
    check("t2_count_full", {29'h0, sb_count}, 32'h4);
    check("t2_st_ready_full", {31'h0, st_ready}, 32'h0);
    check("t2_no_write_on_load", {28'h0, mem_we}, 32'h0);
    cyc();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t2_first_drain_addr", mem_addr, 32'h10);
    cyc();
    @(negedge clk);
    check("t2_st_ready_after_pop", {31'h0, st_ready}, 32'h1);
    check("t2_count_after_pop", {29'h0, sb_count}, 32'h3);
    wait_empty("t2_drained");

    // Partial store hazard: stall, then merged word
    st_valid = 1'b1; st_addr = 32'h104; st_data = 32'hBEEF_BEEF; st_be = 4'h3;
    cyc();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h106;
    @(negedge clk);
    check("t3_stall", {31'h0, ld_ready}, 32'h0);
    check("t3_drain_during_stall", {28'h0, mem_we}, 32'h3);
    cyc();
    @(negedge clk);
    check("t3_accept_after_pop", {31'h0, ld_ready}, 32'h1);
    cyc();
    ld_valid = 1'b0;
    @(negedge clk);
    w = init_word(32'h104 >> 2);
    check("t3_rvalid", {31'h0, ld_rvalid}, 32'h1);
    check("t3_merged", ld_rdata, {w[31:16], 16'hBEEF});

    // Plain load, empty buffer
    cyc();
    ld_valid = 1'b1; ld_addr = 32'h300;
    @(negedge clk);
    check("t4_ready", {31'h0, ld_ready}, 32'h1);
    check("t4_we", {28'h0, mem_we}, 32'h0);
    check("t4_addr", mem_addr, 32'h300);
    cyc();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t4_rvalid", {31'h0, ld_rvalid}, 32'h1);
    check("t4_rdata", ld_rdata, 32'h1234_5678);
    cyc();
    @(negedge clk);
    check("t4_rvalid_pulse", {31'h0, ld_rvalid}, 32'h0);

    // Two full-word stores to one address, then load it
    ld_valid = 1'b1; ld_addr = 32'h200;
    st_valid = 1'b1; st_addr = 32'h40; st_data = 32'h1111_1111; st_be = 4'hF;
    cyc();
    st_data = 32'h2222_2222;
    cyc();
    st_valid = 1'b0; ld_addr = 32'h40;
    @(negedge clk);
`ifdef STORE_FWD_EN
    check("t5_fwd_ready", {31'h0, ld_ready}, 32'h1);
    check("t5_parallel_drain", mem_wdata, 32'h1111_1111);
`else
    check("t5_stall", {31'h0, ld_ready}, 32'h0);
    check("t5_drain_oldest", mem_wdata, 32'h1111_1111);
`endif
    k = 0;
    while (!ld_ready && k < 20) begin
      cyc();
      @(negedge clk);
      k++;
    end
    check("t5_accepted", {31'h0, ld_ready}, 32'h1);
    cyc();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t5_rvalid", {31'h0, ld_rvalid}, 32'h1);
    check("t5_rdata", ld_rdata, 32'h2222_2222);
    wait_empty("t5_drained");

    // Reset while three stores are pending
    ld_valid = 1'b1; ld_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 32'h80 + 32'(i * 4); st_data = 32'h5A5A_0000 + 32'(i); st_be = 4'hF;
      cyc();
    end
    st_valid = 1'b0;
    @(negedge clk);
    check("t6_count", {29'h0, sb_count}, 32'h3);
    cyc();
    ld_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("t6_no_write_in_reset", {28'h0, mem_we}, 32'h0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6_count_cleared", {29'h0, sb_count}, 32'h0);
    check("t6_empty", {31'h0, sb_empty}, 32'h1);
    check("t6_rvalid", {31'h0, ld_rvalid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      check("t6_no_later_write", {28'h0, mem_we}, 32'h0);
    end

    check("writes_outstanding", 32'(wq.size()), 32'h0);
    check("loads_outstanding", 32'(lq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
